// File: rtl/dp_tap_pkg.sv
// Shared types and constants for the dp_tap debug TAP controller.
// IDCODE support is enabled with the DP_TAP_IDCODE_EN macro.
package dp_tap_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

  localparam logic [3:0]  EXTEST    = 4'b0000;
  localparam logic [3:0]  SAMPLE    = 4'b0001;
  localparam logic [3:0]  IDCODE    = 4'b0010;
  localparam logic [3:0]  BYPASS    = 4'b1111;
  localparam logic [31:0] DP_IDCODE = 32'h0BA0_1477;

  // IEEE 1149.1 state transition on a tck rising edge.
  function automatic tap_state_t tap_next(input tap_state_t cur, input logic tms);
    tap_state_t nxt;
    case (cur)
      TLR:     nxt = tms ? TLR    : RTI;
      RTI:     nxt = tms ? SEL_DR : RTI;
      SEL_DR:  nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:  nxt = tms ? EX1_DR : SH_DR;
      SH_DR:   nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:  nxt = tms ? UPD_DR : PA_DR;
      PA_DR:   nxt = tms ? EX2_DR : PA_DR;
      EX2_DR:  nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:  nxt = tms ? SEL_DR : RTI;
      SEL_IR:  nxt = tms ? TLR    : CAP_IR;
      CAP_IR:  nxt = tms ? EX1_IR : SH_IR;
      SH_IR:   nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:  nxt = tms ? UPD_IR : PA_IR;
      PA_IR:   nxt = tms ? EX2_IR : PA_IR;
      EX2_IR:  nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:  nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dp_tap_sync.sv
// Oversampling front end: synchronizes tck/tms/tdi into iclk and
// produces one-iclk tck edge pulses with the matching tms/tdi samples.
module dp_tap_sync
  import dp_tap_pkg::*;
#(
  parameter int sync_stages = 2
) (
  input  logic iclk,
  input  logic iresetn,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [sync_stages-1:0] tck_sync;
  logic [sync_stages-1:0] tms_sync;
  logic [sync_stages-1:0] tdi_sync;
  logic                   tck_prev;

  // Synchronizer chains, edge detect and aligned tms/tdi samples.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      tck_sync <= {sync_stages{1'b0}};
      tms_sync <= {sync_stages{1'b0}};
      tdi_sync <= {sync_stages{1'b0}};
      tck_prev <= 1'b0;
      tck_rise <= 1'b0;
      tck_fall <= 1'b0;
      tms_s    <= 1'b0;
      tdi_s    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[sync_stages-2:0], tck};
      tms_sync <= {tms_sync[sync_stages-2:0], tms};
      tdi_sync <= {tdi_sync[sync_stages-2:0], tdi};
      tck_prev <= tck_sync[sync_stages-1];
      tck_rise <= tck_sync[sync_stages-1] & ~tck_prev;
      tck_fall <= ~tck_sync[sync_stages-1] & tck_prev;
      tms_s    <= tms_sync[sync_stages-1];
      tdi_s    <= tdi_sync[sync_stages-1];
    end
  end

endmodule

// File: rtl/dp_tap_ctrl.sv
// JTAG TAP controller driving the debug boundary scan chain from iclk.
// Define DP_TAP_IDCODE_EN to add the 32-bit IDCODE data register.
module dp_tap_ctrl
  import dp_tap_pkg::*;
#(
  parameter int ir_width    = 4,
  parameter int sync_stages = 2
) (
  input  logic                iclk,
  input  logic                iresetn,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic                bsr_sdi,
  input  logic                bsr_sdo,
  output logic                mode,
  output logic                shift_dr,
  output logic                clk_dr,
  output logic                update_dr,
  output logic [3:0]          tap_state,
  output logic [ir_width-1:0] ir_out
);

  localparam logic [ir_width-1:0] IR_EXTEST  = {ir_width{1'b0}};
  localparam logic [ir_width-1:0] IR_SAMPLE  = ir_width'(SAMPLE);
  localparam logic [ir_width-1:0] IR_CAPTURE = ir_width'(2'b01);
`ifdef DP_TAP_IDCODE_EN
  localparam logic [ir_width-1:0] IR_IDCODE  = ir_width'(IDCODE);
  localparam logic [ir_width-1:0] IR_RESET   = IR_IDCODE;
`else
  localparam logic [ir_width-1:0] IR_BYPASS  = {ir_width{1'b1}};
  localparam logic [ir_width-1:0] IR_RESET   = IR_BYPASS;
`endif

  logic                tck_rise;
  logic                tck_fall;
  logic                tms_s;
  logic                tdi_s;
  tap_state_t          state;
  tap_state_t          next_state;
  logic [ir_width-1:0] ir_shift;
  logic                bypass_reg;
  logic                bsr_sel;
  logic                id_sel;
  logic                id_lsb;
  logic                dr_lsb;

  dp_tap_sync #(
    .sync_stages(sync_stages)
  ) u_sync (
    .iclk    (iclk),
    .iresetn (iresetn),
    .tck     (tck),
    .tms     (tms),
    .tdi     (tdi),
    .tck_rise(tck_rise),
    .tck_fall(tck_fall),
    .tms_s   (tms_s),
    .tdi_s   (tdi_s)
  );

`ifdef DP_TAP_IDCODE_EN
  logic [31:0] id_shift;

  // IDCODE data register: capture the constant, shift LSB first.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      id_shift <= 32'h0000_0000;
    end else if (tck_rise && (state == CAP_DR)) begin
      id_shift <= DP_IDCODE;
    end else if (tck_rise && (state == SH_DR)) begin
      id_shift <= {tdi_s, id_shift[31:1]};
    end
  end

  assign id_sel = (ir_out == IR_IDCODE);
  assign id_lsb = id_shift[0];
`else
  assign id_sel = 1'b0;
  assign id_lsb = 1'b0;
`endif

  // Next-state and data register selection.
  always_comb begin
    next_state = tap_next(state, tms_s);
    bsr_sel    = (ir_out == IR_EXTEST) || (ir_out == IR_SAMPLE);
    if (bsr_sel) begin
      dr_lsb = bsr_sdo;
    end else if (id_sel) begin
      dr_lsb = id_lsb;
    end else begin
      dr_lsb = bypass_reg;
    end
  end

  // TAP FSM, IR/bypass registers and all registered outputs.
  // Capture/shift happen on tck rise; shift_dr, updates and tdo on tck fall,
  // so shift_dr is still low at the capture clk_dr pulse.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      state      <= TLR;
      ir_shift   <= {ir_width{1'b0}};
      ir_out     <= IR_RESET;
      bypass_reg <= 1'b0;
      mode       <= 1'b0;
      shift_dr   <= 1'b0;
      clk_dr     <= 1'b0;
      update_dr  <= 1'b0;
      tdo        <= 1'b0;
      tdo_en     <= 1'b0;
      bsr_sdi    <= 1'b0;
    end else begin
      clk_dr    <= 1'b0;
      update_dr <= 1'b0;
      bsr_sdi   <= tdi_s;
      if (tck_rise) begin
        state <= next_state;
        case (state)
          CAP_IR: ir_shift <= IR_CAPTURE;
          SH_IR:  ir_shift <= {tdi_s, ir_shift[ir_width-1:1]};
          CAP_DR: begin
            bypass_reg <= 1'b0;
            clk_dr     <= bsr_sel;
          end
          SH_DR: begin
            bypass_reg <= tdi_s;
            clk_dr     <= bsr_sel;
          end
          default: ;
        endcase
        if (next_state == TLR) begin
          ir_out <= IR_RESET;
          mode   <= 1'b0;
        end
      end else if (tck_fall) begin
        shift_dr <= (state == SH_DR) && bsr_sel;
        case (state)
          UPD_IR: begin
            ir_out <= ir_shift;
            mode   <= (ir_shift == IR_EXTEST);
          end
          UPD_DR:  update_dr <= bsr_sel;
          default: ;
        endcase
        if (state == SH_IR) begin
          tdo    <= ir_shift[0];
          tdo_en <= 1'b1;
        end else if (state == SH_DR) begin
          tdo    <= dr_lsb;
          tdo_en <= 1'b1;
        end else begin
          tdo    <= 1'b0;
          tdo_en <= 1'b0;
        end
      end
    end
  end

  assign tap_state = state;

endmodule

// File: doc/dp_tap_ctrl.md
Name: dp_tap_ctrl

Overview:
- JTAG TAP controller that drives the debug boundary scan register chain.
- Runs on the internal clock and oversamples the external tck/tms/tdi pins.
- Implements the IEEE 1149.1 16-state FSM, a 4-bit instruction register and a bypass register.
- Generates mode/shift_dr/clk_dr/update_dr for the BSR and muxes the returning serial data onto tdo.

Parameters:
- ir_width, 4, instruction register length (min 2)
- sync_stages, 2, synchronizer depth on tck/tms/tdi (min 2)

Ports:
- iclk  input  1  internal clock, must be >=4x tck frequency
- iresetn  input  1  internal reset
- tck  input  1  JTAG test clock, asynchronous to iclk
- tms  input  1  JTAG test mode select
- tdi  input  1  JTAG test data in
- tdo  output  1  JTAG test data out
- tdo_en  output  1  tdo output enable
- bsr_sdi  output  1  serial data into BSR chain
- bsr_sdo  input  1  serial data from BSR chain
- mode  output  1  BSR mode (1 = drive pdo from update latches)
- shift_dr  output  1  shift data register
- clk_dr  output  1  one-iclk capture/shift enable pulse for BSR
- update_dr  output  1  one-iclk update pulse for BSR
- tap_state  output  4  current FSM state (debug)
- ir_out  output  ir_width  active instruction

Behaviour:
- Clock and reset: single clock iclk; iresetn is asynchronous, active-low.
- Reset values: state TEST_LOGIC_RESET; tdo 0; tdo_en 0; mode 0; shift_dr 0; clk_dr 0; update_dr 0; bsr_sdi 0.
  - ir_out = BYPASS (all ones), or IDCODE when DP_TAP_IDCODE_EN is defined.
  - Synchronizer and edge flops clear to 0.
- Pin sampling:
  - tck, tms and tdi pass through sync_stages flops, then one extra tck flop.
  - tck_rise and tck_fall are one-iclk pulses from the synchronized tck.
  - tms and tdi are used at the value sampled with the same tck_rise.
- FSM advances only on tck_rise, one iclk after the pulse. States are the standard 16:
  - TLR, RTI
  - SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR
  - SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
- Transitions follow IEEE 1149.1 exactly. Five consecutive tck_rise with tms=1 from any state reach TLR.
- Entering TLR forces ir_out to its reset value.
- Instructions:
  - EXTEST = 0000
  - SAMPLE = 0001
  - IDCODE = 0010 (only with the macro)
  - BYPASS = 1111
  - Any other code selects the bypass register.
- mode = 1 only while ir_out == EXTEST.
- DR path, BSR selected (EXTEST/SAMPLE):
  - clk_dr pulses on tck_rise while in CAP_DR or SH_DR.
  - shift_dr = 1 throughout SH_DR.
  - bsr_sdi = synchronized tdi.
  - update_dr pulses on tck_fall while in UPD_DR.
- DR path, bypass selected: clk_dr and update_dr stay 0; the 1-bit bypass register loads 0 in CAP_DR and shifts tdi in SH_DR.
- IR path:
  - Shift register loads 0…01 on tck_rise in CAP_IR.
  - Shifts LSB-out in SH_IR, with tdi entering the MSB.
  - ir_out loads from the shift register on tck_fall in UPD_IR.
- tdo:
  - Registered on tck_fall.
  - Source: IR shift LSB in SH_IR; bsr_sdo, bypass or IDCODE LSB (per instruction) in SH_DR.
  - tdo_en = 1 only in SH_DR/SH_IR; otherwise tdo holds 0.
- Simultaneous events: tck_rise and tck_fall are mutually exclusive by construction.
- Reset mid-shift returns to TLR immediately. No update pulse is produced and the BSR latches are untouched.

Optional Feature:
- Macro DP_TAP_IDCODE_EN.
- Defined:
  - Adds a 32-bit IDCODE register with value from package constant DP_IDCODE (bit0 = 1).
  - IDCODE (0010) is decoded and is the reset/TLR instruction.
  - CAP_DR loads the register; SH_DR shifts it LSB first, tdi in at MSB.
- Undefined: 0010 decodes as bypass; reset/TLR instruction is BYPASS.

Decomposition:
- Package dp_tap_pkg:
  - tap_state_t enum (4-bit encoding, TLR = 4'hF)
  - instruction constants EXTEST/SAMPLE/IDCODE/BYPASS
  - DP_IDCODE constant
- Sub-module dp_tap_sync: synchronizer chain and tck edge detect; outputs tck_rise, tck_fall, tms_s, tdi_s.

Test Plan:
- Reset, then 5 tck with tms=1 from RTI → tap_state = TLR, ir_out = 1111 (or 0010 with macro), mode = 0.
- Shift IR 0000 via SH_IR, then UPD_IR → ir_out = 0000, mode = 1; tdo during the IR shift returns 1,0,0,0 (capture pattern).
- EXTEST, BSR width 8 looped to bsr_sdi/bsr_sdo, shift 0xA5 then 8 more bits:
  - exactly 9 clk_dr pulses (1 capture + 8 shift) for the 0xA5 shift;
  - shift_dr high only in SH_DR;
  - one update_dr pulse in UPD_DR;
  - tdo replays the captured pdi pattern.
- BYPASS, shift 1,0,1,1 → tdo = 0,1,0,1 (one-bit delay); clk_dr and update_dr never pulse.
- iresetn low during SH_DR → outputs at reset values within the same iclk, no update_dr pulse.
- With DP_TAP_IDCODE_EN: after TLR, scan 32 DR bits → tdo yields DP_IDCODE LSB first, bit0 = 1.
